// File: rtl/branch_resolve_predict_unit_if.sv
// branch_resolve_predict_unit_if: execute-stage resolve request and registered resolution results
interface branch_resolve_predict_unit_if #(
    parameter int DataWidth = 32
);
    logic                 resolve_valid;
    logic [2:0]           function3;
    logic [DataWidth-1:0] SRC_1;
    logic [DataWidth-1:0] SRC_2;
    logic [DataWidth-1:0] resolve_pc;
    logic [DataWidth-1:0] branch_offset;
    logic                 predicted_taken;
    logic                 resolve_done;
    logic                 Branch;
    logic                 mispredict;
    logic [DataWidth-1:0] redirect_pc;
    logic                 illegal_funct3;
    modport master (
        output resolve_valid, function3, SRC_1, SRC_2, resolve_pc, branch_offset, predicted_taken,
        input  resolve_done, Branch, mispredict, redirect_pc, illegal_funct3
    );
    modport slave (
        input  resolve_valid, function3, SRC_1, SRC_2, resolve_pc, branch_offset, predicted_taken,
        output resolve_done, Branch, mispredict, redirect_pc, illegal_funct3
    );
endinterface

// File: rtl/branch_resolve_predict_unit.sv
// branch_resolve_predict_unit: RV32I branch resolution with 2-bit counter prediction table
module branch_resolve_predict_unit #(
    parameter int DataWidth  = 32,
    parameter int IndexBits  = 6,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DataWidth-1:0]  lookup_pc,
    output logic                  predict_taken,
    branch_resolve_predict_unit_if.slave rif,
    output logic [CountWidth-1:0] branch_count,
    output logic [CountWidth-1:0] mispredict_count
);
    localparam int Entries = 1 << IndexBits;
    logic [1:0]           bht [Entries];
    logic [IndexBits-1:0] lookup_idx;
    logic [IndexBits-1:0] update_idx;
    logic                 unused_bits;
    logic                 eq, lt_s, lt_u, cmp, illegal, taken, miss;
    logic [1:0]           entry, next_entry;
    logic [DataWidth-1:0] target;
    assign lookup_idx    = lookup_pc[IndexBits+1:2];
    assign update_idx    = rif.resolve_pc[IndexBits+1:2];
    assign unused_bits   = ^{lookup_pc[DataWidth-1:IndexBits+2], lookup_pc[1:0]};
    assign predict_taken = bht[lookup_idx][1];
    // condition evaluation: funct3[2:1] picks the compare, funct3[0] inverts it
    always_comb begin
        eq         = rif.SRC_1 == rif.SRC_2;
        lt_s       = $signed(rif.SRC_1) < $signed(rif.SRC_2);
        lt_u       = rif.SRC_1 < rif.SRC_2;
        illegal    = rif.function3[2:1] == 2'b01;
        cmp        = rif.function3[2] ? (rif.function3[1] ? lt_u : lt_s) : eq;
        taken      = !illegal && (cmp ^ rif.function3[0]);
        miss       = !illegal && (taken != rif.predicted_taken);
        target     = taken ? rif.resolve_pc + rif.branch_offset : rif.resolve_pc + DataWidth'(4);
        entry      = bht[update_idx];
        next_entry = taken ? (entry == 2'b11 ? entry : entry + 2'b01)
                           : (entry == 2'b00 ? entry : entry - 2'b01);
    end
    // registered results, table update and saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Entries; i++) bht[i] <= 2'b01;
            rif.resolve_done   <= 1'b0;
            rif.Branch         <= 1'b0;
            rif.mispredict     <= 1'b0;
            rif.illegal_funct3 <= 1'b0;
            rif.redirect_pc    <= '0;
            branch_count       <= '0;
            mispredict_count   <= '0;
        end else begin
            rif.resolve_done   <= rif.resolve_valid;
            rif.mispredict     <= rif.resolve_valid && miss;
            rif.illegal_funct3 <= rif.resolve_valid && illegal;
            if (rif.resolve_valid) begin
                rif.Branch      <= taken;
                rif.redirect_pc <= target;
            end
            if (rif.resolve_valid && !illegal) begin
                bht[update_idx] <= next_entry;
                if (branch_count != '1) branch_count <= branch_count + 1'b1;
            end
            if (rif.resolve_valid && miss && mispredict_count != '1)
                mispredict_count <= mispredict_count + 1'b1;
        end
    end
endmodule

// File: doc/branch_resolve_predict_unit.md
# branch_resolve_predict_unit

Parametrised branch resolution and prediction unit for the 5-stage SV32I pipeline. It evaluates all six RV32I conditional-branch conditions, with correct signed and unsigned compares, in the execute stage. It also maintains a table of 2-bit saturating counters that the fetch stage reads for a taken/not-taken hint. Each resolved branch produces a registered outcome, a misprediction flush pulse and a redirect PC one cycle later, plus saturating performance counters.

## Interface
- DataWidth, 32, width of operands and PCs
- IndexBits, 6, log2 of branch history table entries (64 by default)
- CountWidth, 16, width of each performance counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- lookup_pc  input  DataWidth  fetch-stage PC; indexes the table with bits [IndexBits+1:2]
- predict_taken  output  1  combinational; bit 1 of the addressed counter
- resolve_valid  input  1  execute-stage branch present this cycle
- function3  input  3  branch funct3
- SRC_1, SRC_2  input  DataWidth  rs1 and rs2 operands
- resolve_pc  input  DataWidth  PC of the resolving branch; also indexes the table for update
- branch_offset  input  DataWidth  sign-extended B-type immediate
- predicted_taken  input  1  prediction carried down the pipe with this branch
- resolve_done  output  1  registered pulse; the results below are valid
- Branch  output  1  registered actual outcome
- mispredict  output  1  registered pulse; the pipeline must flush and redirect
- redirect_pc  output  DataWidth  registered correct next PC
- illegal_funct3  output  1  registered pulse for funct3 010 or 011
- branch_count, mispredict_count  output  CountWidth  saturating event counters

## Operation
- Conditions:
  - 000 BEQ: equal
  - 001 BNE: not equal
  - 100 BLT: signed less-than
  - 101 BGE: signed greater-or-equal
  - 110 BLTU: unsigned less-than
  - 111 BGEU: unsigned greater-or-equal
- Signed compares use $signed on both operands.
- funct3 010/011 are illegal:
  - taken = 0, illegal_funct3 = 1, mispredict = 0, redirect_pc = resolve_pc + 4
  - no table update, no counter increment
- Target computation is mod 2^DataWidth (wrap, no overflow flag):
  - taken: redirect_pc = resolve_pc + branch_offset
  - not taken: redirect_pc = resolve_pc + 4
- mispredict = (taken != predicted_taken), legal funct3 only.
- Table entry update on a legal resolve:
  - taken: increment, saturating at 11
  - not taken: decrement, saturating at 00
  - states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
- Performance counters:
  - branch_count increments on every legal resolve
  - mispredict_count increments on every mispredict
  - both hold at all-ones; no wrap
- Aliasing between PCs sharing an index is accepted; there are no tags.

## Timing
- Reset (rst_n low at a clock edge) sets:
  - every table entry to 01, so predict_taken = 0
  - resolve_done, Branch, mispredict, illegal_funct3 to 0
  - redirect_pc and both counters to 0
- Reset has priority over a concurrent resolve_valid. A branch in flight at reset is discarded: no update, no pulse.
- Latency:
  - resolve_valid sampled at edge N → results visible after edge N, held for one cycle.
  - resolve_done, mispredict and illegal_funct3 are one-cycle pulses unless resolve_valid is high again.
  - Branch and redirect_pc hold their last value until the next resolve.
- Back-to-back resolves are accepted every cycle; throughput is 1 per cycle.
- Table update takes effect at edge N; predict_taken reflects it from the cycle after.
- Same-cycle lookup and update of one index: lookup returns the pre-update value (read-before-write, no bypass).
- predict_taken is purely combinational from lookup_pc and table state; there is no lookup-side register.

## Test plan
- Reset, then lookup_pc = 0x0 → predict_taken = 0; all outputs 0.
- BLT with SRC_1 = 0xFFFFFFFF, SRC_2 = 1, predicted_taken = 0 → Branch = 1, mispredict = 1, redirect_pc = resolve_pc + offset one cycle later. Same operands with BLTU → Branch = 0, mispredict = 0, redirect_pc = resolve_pc + 4.
- Three taken BEQs at resolve_pc = 0x100 → entry goes 01→10→11→11 (saturates). Lookup 0x100 → predict_taken = 1. Then one not-taken → 10, still predicts taken.
- funct3 = 010 with resolve_valid → illegal_funct3 pulse; counters and table unchanged; redirect_pc = resolve_pc + 4.
- CountWidth = 4: 20 mispredicting resolves back-to-back → mispredict_count = branch_count = 15, held there.
- rst_n low in the same cycle as a taken resolve → no pulses; entry remains 01; counters 0.
- Wrap: resolve_pc = 0xFFFFFFFC, offset = 8, taken → redirect_pc = 0x00000004.
